// File: rtl/qmem_wb_ctrl.sv
// Q-table memory interface: read-address generation, valid-tracked write-back pipeline,
// one-hot bank write issue with byte enables, RAW hazard detection and write/drop statistics.
module qmem_wb_ctrl #(
    parameter int unsigned S_W     = 12,
    parameter int unsigned N_ACT   = 4,
    parameter int unsigned BYTE_EN = 4,
    parameter int unsigned WB_LAT  = 7,
    parameter int unsigned A_STAGE = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned A_W    = $clog2(N_ACT),
    localparam int unsigned WB_W   = N_ACT * BYTE_EN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [S_W-1:0]    S,
    input  logic [A_W-1:0]    A,
    input  logic              wen,
    input  logic              flush,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic              raw_hazard,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [WB_W-1:0]   wen_bank,
    output logic [N_ACT-1:0]  en_bank,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned LAST = WB_LAT - 1;

    logic           slot_v [WB_LAT];
    logic [S_W-1:0] slot_s [WB_LAT];
    logic [A_W-1:0] slot_a [WB_LAT];

    logic             ret_v;
    logic [S_W-1:0]   ret_s;
    logic [A_W-1:0]   ret_a;
    logic [N_ACT-1:0] en_next;
    logic [WB_W-1:0]  wen_next;
    logic             hit;

    assign RD_ADDR = ADDR_BASE + (ADDR_W'(S) << 2);

    // Retire stage; when the action is sampled in the last stage it bypasses the slot storage.
    assign ret_v = slot_v[LAST];
    assign ret_s = slot_s[LAST];
    assign ret_a = (A_STAGE == LAST) ? A : slot_a[LAST];

    // Valid bits: the only slot state that needs reset; flush drops the incoming lookup too.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned k = 0; k < WB_LAT; k++) begin
                slot_v[k] <= 1'b0;
            end
        end else begin
            slot_v[0] <= rd_valid;
            for (int unsigned k = 1; k < WB_LAT; k++) begin
                slot_v[k] <= slot_v[k-1];
            end
        end
    end

    // Payload shift; contents are meaningless unless the matching valid bit is set.
    always_ff @(posedge clk) begin
        slot_s[0] <= S;
        slot_a[0] <= A;
        for (int unsigned k = 1; k < WB_LAT; k++) begin
            slot_s[k] <= slot_s[k-1];
            slot_a[k] <= (k == A_STAGE + 1) ? A : slot_a[k-1];
        end
    end

    // Bank decode for the retiring action.
    always_comb begin
        en_next  = '0;
        wen_next = '0;
        for (int unsigned i = 0; i < N_ACT; i++) begin
            if (ret_a == A_W'(i)) begin
                en_next[i]                    = 1'b1;
                wen_next[i*BYTE_EN +: BYTE_EN] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WR_ADDR  <= '0;
            en_bank  <= '0;
            wen_bank <= '0;
            wr_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            en_bank  <= '0;
            wen_bank <= '0;
            if (ret_v && wen) begin
                WR_ADDR  <= ADDR_BASE + (ADDR_W'(ret_s) << 2);
                en_bank  <= en_next;
                wen_bank <= wen_next;
                if (!(&wr_cnt)) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end else if (ret_v) begin
                if (!(&drop_cnt)) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Hazard covers every in-flight slot plus the write pulse currently on the bank port.
    always_comb begin
        hit = 1'b0;
        for (int unsigned k = 0; k < WB_LAT; k++) begin
            if (slot_v[k] && (slot_s[k] == S)) begin
                hit = 1'b1;
            end
        end
        if ((|en_bank) && (WR_ADDR == RD_ADDR)) begin
            hit = 1'b1;
        end
        raw_hazard = rd_valid && hit;
    end

endmodule

// File: tb/tb_qmem_wb_ctrl.sv
// Scoreboard bench for qmem_wb_ctrl: default build plus a narrow, short-latency build.
module tb_qmem_wb_ctrl;

    localparam int NCYC = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic        rst, rd_valid, wen, flush;
    logic [11:0] s;
    logic [1:0]  a;
    logic [31:0] rd_addr, wr_addr;
    logic        raw_hazard;
    logic [15:0] wen_bank;
    logic [3:0]  en_bank;
    logic [15:0] wr_cnt, drop_cnt;

    // Parameter-sweep DUT
    logic        b_rst, b_rd_valid, b_wen, b_flush;
    logic [11:0] b_s;
    logic [2:0]  b_a;
    logic [31:0] b_rd_addr, b_wr_addr;
    logic        b_raw_hazard;
    logic [15:0] b_wen_bank;
    logic [7:0]  b_en_bank;
    logic [3:0]  b_wr_cnt, b_drop_cnt;

    qmem_wb_ctrl u_dut0 (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .S(s), .A(a), .wen(wen), .flush(flush),
        .RD_ADDR(rd_addr), .raw_hazard(raw_hazard), .WR_ADDR(wr_addr), .wen_bank(wen_bank),
        .en_bank(en_bank), .wr_cnt(wr_cnt), .drop_cnt(drop_cnt)
    );

    qmem_wb_ctrl #(
        .N_ACT(8), .BYTE_EN(2), .WB_LAT(3), .A_STAGE(0), .ADDR_BASE(32'h1000), .CNT_W(4)
    ) u_dut1 (
        .clk(clk), .rst(b_rst), .rd_valid(b_rd_valid), .S(b_s), .A(b_a), .wen(b_wen),
        .flush(b_flush), .RD_ADDR(b_rd_addr), .raw_hazard(b_raw_hazard), .WR_ADDR(b_wr_addr),
        .wen_bank(b_wen_bank), .en_bank(b_en_bank), .wr_cnt(b_wr_cnt), .drop_cnt(b_drop_cnt)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [15:0] en;
        logic [15:0] wb;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    // Per-cycle stimulus schedule, DUT0
    bit sch_rst[NCYC], sch_rd[NCYC], sch_wen[NCYC], sch_flush[NCYC];
    int sch_s[NCYC], sch_a[NCYC];
    bit          e_vld[NCYC];
    logic [31:0] e_addr[NCYC];
    logic [15:0] e_en[NCYC], e_wb[NCYC];
    int haz_exp[NCYC];
    bit cnt_chk[NCYC], zero_chk[NCYC], idle_chk[NCYC];
    int cnt_wr[NCYC], cnt_dr[NCYC];

    // Per-cycle stimulus schedule, DUT1
    bit b_sch_rst[NCYC], b_sch_rd[NCYC], b_sch_wen[NCYC];
    int b_sch_s[NCYC], b_sch_a[NCYC];
    bit          b_e_vld[NCYC];
    logic [31:0] b_e_addr[NCYC];
    logic [15:0] b_e_en[NCYC], b_e_wb[NCYC];
    bit b_cnt_chk[NCYC], b_zero_chk[NCYC];
    int b_cnt_wr[NCYC], b_cnt_dr[NCYC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic lookup(input int t, input int sv, input int av, input bit w, input bit ex,
                          input logic [31:0] ea, input logic [15:0] ee, input logic [15:0] ew);
        sch_rd[t]    = 1'b1;
        sch_s[t]     = sv;
        sch_a[t+2]   = av;
        sch_wen[t+7] = w;
        e_vld[t]     = ex;
        e_addr[t]    = ea;
        e_en[t]      = ee;
        e_wb[t]      = ew;
    endtask

    task automatic b_lookup(input int t, input int sv, input int av, input bit w, input bit ex,
                            input logic [31:0] ea, input logic [15:0] ee, input logic [15:0] ew);
        b_sch_rd[t]    = 1'b1;
        b_sch_s[t]     = sv;
        b_sch_a[t+1]   = av;
        b_sch_wen[t+3] = w;
        b_e_vld[t]     = ex;
        b_e_addr[t]    = ea;
        b_e_en[t]      = ee;
        b_e_wb[t]      = ew;
    endtask

    task automatic exp_cnt(input int c, input int w, input int d);
        cnt_chk[c] = 1'b1;
        cnt_wr[c]  = w;
        cnt_dr[c]  = d;
    endtask

    // Write monitor, DUT0
    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (en_bank !== 4'b0) begin
                if (q0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut0_unexpected_write cyc=%0d en_bank=%b required=none", cyc, en_bank);
                end else begin
                    e0 = q0.pop_front();
                    chk("dut0_wr_cycle", 64'(cyc), 64'(e0.cyc));
                    chk("dut0_wr_addr", 64'(wr_addr), 64'(e0.addr));
                    chk("dut0_en_bank", 64'(en_bank), 64'(e0.en));
                    chk("dut0_wen_bank", 64'(wen_bank), 64'(e0.wb));
                end
            end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
                e0 = q0.pop_front();
                chk("dut0_missing_write", 64'(en_bank), 64'(e0.en));
            end
        end
    end

    // Write monitor, DUT1
    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (b_en_bank !== 8'b0) begin
                if (q1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut1_unexpected_write cyc=%0d en_bank=%b required=none", cyc, b_en_bank);
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1_wr_cycle", 64'(cyc), 64'(e1.cyc));
                    chk("dut1_wr_addr", 64'(b_wr_addr), 64'(e1.addr));
                    chk("dut1_en_bank", 64'(b_en_bank), 64'(e1.en));
                    chk("dut1_wen_bank", 64'(b_wen_bank), 64'(e1.wb));
                end
            end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
                e1 = q1.pop_front();
                chk("dut1_missing_write", 64'(b_en_bank), 64'(e1.en));
            end
        end
    end

    initial begin
        rst = 1'b1; rd_valid = 1'b0; wen = 1'b0; flush = 1'b0; s = '0; a = '0;
        b_rst = 1'b1; b_rd_valid = 1'b0; b_wen = 1'b0; b_flush = 1'b0; b_s = '0; b_a = '0;
        for (int c = 0; c < NCYC; c++) haz_exp[c] = -1;

        // Reset
        sch_rst[0] = 1'b1; sch_rst[1] = 1'b1; zero_chk[2] = 1'b1;
        // Single lookup
        lookup(5, 'h02A, 2, 1'b1, 1'b1, 32'h0A8, 16'h4, 16'h0F00);
        haz_exp[5] = 0;
        exp_cnt(13, 1, 0);
        idle_chk[14] = 1'b1;
        // Eight lookups, wen alternating 1/0
        lookup(20, 0, 0, 1'b1, 1'b1, 32'h00, 16'h1, 16'h000F);
        lookup(21, 1, 1, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        lookup(22, 2, 2, 1'b1, 1'b1, 32'h08, 16'h4, 16'h0F00);
        lookup(23, 3, 3, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        lookup(24, 4, 0, 1'b1, 1'b1, 32'h10, 16'h1, 16'h000F);
        lookup(25, 5, 1, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        lookup(26, 6, 2, 1'b1, 1'b1, 32'h18, 16'h4, 16'h0F00);
        lookup(27, 7, 3, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        exp_cnt(36, 5, 4);
        // Back-to-back committed writes
        lookup(40, 'h10, 3, 1'b1, 1'b1, 32'h40, 16'h8, 16'hF000);
        lookup(41, 'h11, 1, 1'b1, 1'b1, 32'h44, 16'h2, 16'h00F0);
        lookup(42, 'h12, 0, 1'b1, 1'b1, 32'h48, 16'h1, 16'h000F);
        exp_cnt(51, 8, 4);
        // Hazard against in-flight slots
        lookup(60, 'h100, 1, 1'b1, 1'b1, 32'h400, 16'h2, 16'h00F0);
        haz_exp[60] = 0;
        lookup(63, 'h101, 0, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        haz_exp[63] = 0;
        lookup(64, 'h100, 0, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        haz_exp[64] = 1;
        exp_cnt(73, 9, 6);
        // Hazard against the write landing this cycle
        lookup(80, 'h200, 3, 1'b1, 1'b1, 32'h800, 16'h8, 16'hF000);
        lookup(88, 'h200, 0, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        haz_exp[88] = 1;
        exp_cnt(97, 10, 7);
        // Hazard against the slot retiring this cycle
        lookup(100, 'h300, 1, 1'b1, 1'b1, 32'hC00, 16'h2, 16'h00F0);
        lookup(107, 'h300, 0, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        haz_exp[107] = 1;
        exp_cnt(116, 11, 8);
        // Hazard gone once the pulse cycle has passed
        lookup(120, 'h310, 2, 1'b1, 1'b1, 32'hC40, 16'h4, 16'h0F00);
        lookup(129, 'h310, 0, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
        haz_exp[129] = 0;
        exp_cnt(138, 12, 9);
        // Flush with a same-cycle lookup: nothing reaches the banks
        lookup(150, 1, 0, 1'b1, 1'b0, 32'h0, 16'h0, 16'h0);
        lookup(151, 2, 0, 1'b1, 1'b0, 32'h0, 16'h0, 16'h0);
        lookup(152, 3, 0, 1'b1, 1'b0, 32'h0, 16'h0, 16'h0);
        lookup(154, 3, 0, 1'b1, 1'b0, 32'h0, 16'h0, 16'h0);
        sch_flush[154] = 1'b1;
        haz_exp[154] = 1;
        exp_cnt(165, 12, 9);
        // Reset mid-flight with wen held high
        lookup(180, 'h050, 1, 1'b1, 1'b0, 32'h0, 16'h0, 16'h0);
        for (int c = 180; c <= 190; c++) sch_wen[c] = 1'b1;
        sch_rst[184] = 1'b1;
        zero_chk[185] = 1'b1;
        zero_chk[192] = 1'b1;

        // Sweep build: WB_LAT=3, A_STAGE=0, 8 banks x 2 byte enables, base 0x1000, 4-bit counters
        b_sch_rst[0] = 1'b1; b_sch_rst[1] = 1'b1; b_zero_chk[2] = 1'b1;
        b_lookup(5, 5, 7, 1'b1, 1'b1, 32'h1014, 16'h80, 16'hC000);
        b_cnt_chk[9] = 1'b1; b_cnt_wr[9] = 1; b_cnt_dr[9] = 0;
        for (int i = 0; i < 16; i++)
            b_lookup(20 + i, i, 0, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 16'h01, 16'h0003);
        b_cnt_chk[30] = 1'b1; b_cnt_wr[30] = 8;  b_cnt_dr[30] = 0;
        b_cnt_chk[41] = 1'b1; b_cnt_wr[41] = 15; b_cnt_dr[41] = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc        = c;
            rst        = sch_rst[c];
            flush      = sch_flush[c];
            rd_valid   = sch_rd[c];
            s          = 12'(sch_s[c]);
            a          = 2'(sch_a[c]);
            wen        = sch_wen[c];
            b_rst      = b_sch_rst[c];
            b_rd_valid = b_sch_rd[c];
            b_s        = 12'(b_sch_s[c]);
            b_a        = 3'(b_sch_a[c]);
            b_wen      = b_sch_wen[c];
            if (e_vld[c])   q0.push_back('{c + 8, e_addr[c], e_en[c], e_wb[c]});
            if (b_e_vld[c]) q1.push_back('{c + 4, b_e_addr[c], b_e_en[c], b_e_wb[c]});
            @(negedge clk);
            if (haz_exp[c] >= 0) chk("dut0_raw_hazard", 64'(raw_hazard), 64'(haz_exp[c]));
            if (cnt_chk[c]) begin
                chk("dut0_wr_cnt", 64'(wr_cnt), 64'(cnt_wr[c]));
                chk("dut0_drop_cnt", 64'(drop_cnt), 64'(cnt_dr[c]));
            end
            if (zero_chk[c]) begin
                chk("dut0_zero_wr_addr", 64'(wr_addr), 64'(0));
                chk("dut0_zero_en_bank", 64'(en_bank), 64'(0));
                chk("dut0_zero_wen_bank", 64'(wen_bank), 64'(0));
                chk("dut0_zero_wr_cnt", 64'(wr_cnt), 64'(0));
                chk("dut0_zero_drop_cnt", 64'(drop_cnt), 64'(0));
            end
            if (idle_chk[c]) begin
                chk("dut0_idle_en_bank", 64'(en_bank), 64'(0));
                chk("dut0_idle_wen_bank", 64'(wen_bank), 64'(0));
            end
            if (b_cnt_chk[c]) begin
                chk("dut1_wr_cnt", 64'(b_wr_cnt), 64'(b_cnt_wr[c]));
                chk("dut1_drop_cnt", 64'(b_drop_cnt), 64'(b_cnt_dr[c]));
            end
            if (b_zero_chk[c]) begin
                chk("dut1_zero_wr_addr", 64'(b_wr_addr), 64'(0));
                chk("dut1_zero_en_bank", 64'(b_en_bank), 64'(0));
                chk("dut1_zero_wr_cnt", 64'(b_wr_cnt), 64'(0));
            end
        end

        @(negedge clk);
        chk("dut0_pending_writes", 64'(q0.size()), 64'(0));
        chk("dut1_pending_writes", 64'(q1.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
